// File: rtl/ramp_check_pkg.sv
// Shared definitions for the ramp test-stream checker family.
//   - state_e        : lock tracker states
//   - D_CONST_DEFAULT: value expected on the constant channel d
//   - *_BIT          : bit positions of the per-channel flags / err_flags
//   - RUN_W, run_t   : width of the consecutive match/miss run counters
package ramp_check_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [15:0] D_CONST_DEFAULT = 16'h7FFF;

  localparam int A_BIT = 0;
  localparam int B_BIT = 1;
  localparam int C_BIT = 2;
  localparam int D_BIT = 3;

  localparam int RUN_W = 4;
  typedef logic [RUN_W-1:0] run_t;

endpackage

// File: rtl/ramp_relation_check.sv
// Combinational relation check of one four-channel ramp sample.
// Ports:
//   a, b, c, d  in  16  sample channels
//   expected    in  16  value channel a should carry this sample
//   flags       out 4   mismatch per channel, [A_BIT]=a .. [D_BIT]=d
module ramp_relation_check
  import ramp_check_pkg::*;
#(
  parameter logic [15:0] D_CONST = D_CONST_DEFAULT
) (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  input  logic signed [15:0] c,
  input  logic signed [15:0] d,
  input  logic        [15:0] expected,
  output logic        [3:0]  flags
);

  logic [15:0] a_u;
  logic [15:0] neg_a;
  logic [15:0] half_a;

  assign a_u    = a;
  // Two's-complement negation wraps, so 0x8000 maps onto itself.
  assign neg_a  = 16'h0000 - a_u;
  // Logical (not arithmetic) shift: the top bit is always zero.
  assign half_a = {1'b0, a_u[15:1]};

  assign flags[A_BIT] = (a_u != expected);
  assign flags[B_BIT] = (16'(b) != neg_a);
  assign flags[C_BIT] = (16'(c) != half_a);
  assign flags[D_BIT] = (16'(d) != D_CONST);

endmodule

// File: rtl/ramp_stream_checker.sv
// Receive-side checker for the four-channel ramp test stream.
// Locks onto the ramp after LOCK_COUNT consecutive correct samples (following
// a seeding sample), then checks every valid sample and keeps debug stats.
// Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   asynchronous active-low reset
//   in_valid     in  1   qualifies a/b/c/d
//   a, b, c, d   in  16  sample channels
//   clear_stats  in  1   synchronous clear of the statistics outputs
//   locked       out 1   high while LOCKED
//   err_sticky   out 1   set on first counted error
//   err_flags    out 4   sticky per-channel error bits
//   err_count    out 16  counted failing samples, saturating
//   first_err_a  out 16  a of the first counted failing sample
//   sample_count out 32  valid samples checked while LOCKED, wraps
module ramp_stream_checker
  import ramp_check_pkg::*;
#(
  parameter int          LOCK_COUNT = 4,
  parameter int          LOSS_COUNT = 2,
  parameter logic [15:0] D_CONST    = D_CONST_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  input  logic signed [15:0] c,
  input  logic signed [15:0] d,
  input  logic               clear_stats,
  output logic               locked,
  output logic               err_sticky,
  output logic        [3:0]  err_flags,
  output logic        [15:0] err_count,
  output logic        [15:0] first_err_a,
  output logic        [31:0] sample_count
);

  localparam run_t LOCK_RUN = run_t'(LOCK_COUNT);
  localparam run_t LOSS_RUN = run_t'(LOSS_COUNT);

  state_e      state_q,        state_d;
  logic [15:0] expected_q,     expected_d;
  run_t        match_run_q,    match_run_d;
  run_t        miss_run_q,     miss_run_d;
  logic        seeded_q,       seeded_d;
  logic        err_sticky_q,   err_sticky_d;
  logic [3:0]  err_flags_q,    err_flags_d;
  logic [15:0] err_count_q,    err_count_d;
  logic [15:0] first_err_a_q,  first_err_a_d;
  logic [31:0] sample_count_q, sample_count_d;

  logic [3:0]  flags;
  logic        any_flag;
  logic        count_err;
  logic [15:0] a_u;

  assign a_u = a;

  ramp_relation_check #(
    .D_CONST (D_CONST)
  ) u_relation (
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .expected (expected_q),
    .flags    (flags)
  );

  assign any_flag = |flags;

  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    match_run_d    = match_run_q;
    miss_run_d     = miss_run_q;
    seeded_d       = seeded_q;
    err_sticky_d   = err_sticky_q;
    err_flags_d    = err_flags_q;
    err_count_d    = err_count_q;
    first_err_a_d  = first_err_a_q;
    sample_count_d = sample_count_q;
    count_err      = 1'b0;

    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          // While searching, the ramp is re-anchored on every sample.
          expected_d = a_u + 16'd1;
          if (!seeded_q) begin
            seeded_d    = 1'b1;
            match_run_d = '0;
          end else if (any_flag) begin
            match_run_d = '0;
          end else begin
            match_run_d = match_run_q + run_t'(1);
          end
          if (match_run_d == LOCK_RUN) begin
            state_d    = LOCKED;
            miss_run_d = '0;
          end
        end
        LOCKED: begin
          expected_d     = expected_q + 16'd1;
          sample_count_d = sample_count_q + 32'd1;
          if (any_flag) begin
            count_err  = 1'b1;
            miss_run_d = miss_run_q + run_t'(1);
          end else begin
            miss_run_d = '0;
          end
          // On loss, the failing sample itself becomes the new seed.
          if (miss_run_d == LOSS_RUN) begin
            state_d     = SEARCH;
            seeded_d    = 1'b1;
            expected_d  = a_u + 16'd1;
            match_run_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    // A clear in the same cycle suppresses the error being counted.
    if (count_err && !clear_stats) begin
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
      if (!err_sticky_q) begin
        first_err_a_d = a_u;
      end
      err_sticky_d = 1'b1;
      err_flags_d  = err_flags_q | flags;
    end

    if (clear_stats) begin
      err_sticky_d   = 1'b0;
      err_flags_d    = '0;
      err_count_d    = '0;
      first_err_a_d  = '0;
      sample_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= SEARCH;
      expected_q     <= '0;
      match_run_q    <= '0;
      miss_run_q     <= '0;
      seeded_q       <= 1'b0;
      err_sticky_q   <= 1'b0;
      err_flags_q    <= '0;
      err_count_q    <= '0;
      first_err_a_q  <= '0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      match_run_q    <= match_run_d;
      miss_run_q     <= miss_run_d;
      seeded_q       <= seeded_d;
      err_sticky_q   <= err_sticky_d;
      err_flags_q    <= err_flags_d;
      err_count_q    <= err_count_d;
      first_err_a_q  <= first_err_a_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign err_sticky   = err_sticky_q;
  assign err_flags    = err_flags_q;
  assign err_count    = err_count_q;
  assign first_err_a  = first_err_a_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_ramp_stream_checker.sv
// Scoreboard bench for ramp_stream_checker: the driver applies a sample on the
// falling edge, advances a behavioural model and queues the expected outputs;
// a monitor pops and compares just after the following rising edge.
module tb_ramp_stream_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 2;
  localparam int DC     = 32'h7FFF;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] a = '0, b = '0, c = '0, d = '0;
  logic               clear_stats = 1'b0;
  logic               locked, err_sticky;
  logic        [3:0]  err_flags;
  logic        [15:0] err_count, first_err_a;
  logic        [31:0] sample_count;

  ramp_stream_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .D_CONST(16'h7FFF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
    .clear_stats(clear_stats), .locked(locked), .err_sticky(err_sticky),
    .err_flags(err_flags), .err_count(err_count), .first_err_a(first_err_a),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        locked;
    bit        sticky;
    bit [3:0]  flags;
    int        cnt;
    int        first;
    bit [31:0] samp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Behavioural model: plain integers, everything modulo 65536.
  bit        m_locked, m_seeded, m_sticky;
  int        m_exp, m_match, m_miss, m_cnt, m_first;
  bit [3:0]  m_flags;
  bit [31:0] m_samp;

  task automatic model_reset();
    m_locked = 0; m_seeded = 0; m_sticky = 0;
    m_exp = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_first = 0;
    m_flags = 0; m_samp = 0;
  endtask

  task automatic model_step(input bit v, input int av, input int bv, input int cv,
                            input int dv, input bit clr);
    bit [3:0] f;
    f[0] = (av != m_exp);
    f[1] = (bv != (65536 - av) % 65536);
    f[2] = (cv != av / 2);
    f[3] = (dv != DC);
    if (v) begin
      if (!m_locked) begin
        if (!m_seeded) begin
          m_seeded = 1;
          m_match  = 0;
        end else begin
          m_match = (f == 0) ? m_match + 1 : 0;
        end
        m_exp = (av + 1) % 65536;
        if (m_match == LOCK_N) begin
          m_locked = 1;
          m_miss   = 0;
        end
      end else begin
        m_exp  = (m_exp + 1) % 65536;
        m_samp = m_samp + 1;
        if (f != 0) begin
          if (!clr) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (!m_sticky) m_first = av;
            m_sticky = 1;
            m_flags  = m_flags | f;
          end
          m_miss = m_miss + 1;
        end else begin
          m_miss = 0;
        end
        if (m_miss == LOSS_N) begin
          m_locked = 0;
          m_exp    = (av + 1) % 65536;
          m_match  = 0;
        end
      end
    end
    if (clr) begin
      m_cnt = 0; m_sticky = 0; m_flags = 0; m_first = 0; m_samp = 0;
    end
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One driven cycle: apply inputs, advance the model, queue the expectation.
  task automatic cycle(input bit v, input int av, input int bv, input int cv,
                       input int dv, input bit clr);
    exp_t e;
    @(negedge clk);
    in_valid    = v;
    a           = 16'(av);
    b           = 16'(bv);
    c           = 16'(cv);
    d           = 16'(dv);
    clear_stats = clr;
    model_step(v, av & 32'hFFFF, bv & 32'hFFFF, cv & 32'hFFFF, dv & 32'hFFFF, clr);
    e.locked = m_locked; e.sticky = m_sticky; e.flags = m_flags;
    e.cnt = m_cnt; e.first = m_first; e.samp = m_samp;
    sb_q.push_back(e);
  endtask

  task automatic good(input int x, input bit clr = 0);
    int xm;
    xm = x & 32'hFFFF;
    cycle(1, xm, (65536 - xm) % 65536, xm / 2, DC, clr);
  endtask

  task automatic gap();
    cycle(0, int'($urandom), int'($urandom), int'($urandom), int'($urandom), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; clear_stats = 1'b0;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_flags", err_flags, 0);
    chk("rst_count", err_count, 0);
    chk("rst_first", first_err_a, 0);
    chk("rst_samples", sample_count, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: outputs of a sample appear after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_txn++;
        chk("locked", locked, e.locked);
        chk("err_sticky", err_sticky, e.sticky);
        chk("err_flags", err_flags, e.flags);
        chk("err_count", err_count, e.cnt);
        chk("first_err_a", first_err_a, e.first);
        chk("sample_count", sample_count, e.samp);
        $display("txn %0d: v=%0b a=%04h clr=%0b -> locked=%0b cnt=%0d flags=%b samples=%0d",
                 n_txn, in_valid, a, clear_stats, locked, err_count, err_flags, sample_count);
      end
    end
  end

  initial begin
    int r;
    model_reset();
    do_reset();

    // Plain ramp from zero: lock after a=4, ten LOCKED samples by a=14.
    for (int i = 0; i <= 14; i++) good(i);

    // Wrap across 0xFFFF -> 0x0000.
    do_reset();
    for (int i = 16'hFFF8; i <= 32'h10004; i++) good(i);

    // Ramp through 0x8000, where b must also be 0x8000.
    do_reset();
    for (int i = 16'h7FF8; i <= 16'h8004; i++) good(i);

    // Single corrupted b at 0x10, then a jump from 0x20 to 0x100.
    do_reset();
    for (int i = 0; i <= 16'h20; i++) begin
      if (i == 16'h10) cycle(1, i, 16'h1234, i / 2, DC, 0);
      else good(i);
    end
    for (int i = 16'h100; i <= 16'h10A; i++) good(i);

    // d error masked by clear_stats in the same cycle, then a counted d error.
    for (int i = 16'h10B; i <= 16'h10E; i++) good(i);
    cycle(1, 16'h10F, 65536 - 16'h10F, 16'h10F / 2, 16'h7FFE, 1);
    good(16'h110);
    cycle(1, 16'h111, 65536 - 16'h111, 16'h111 / 2, 16'h7FFE, 0);
    good(16'h112);

    // A three-cycle gap mid-ramp, then reset while locked.
    for (int i = 16'h113; i <= 16'h115; i++) good(i);
    for (int i = 0; i < 3; i++) gap();
    for (int i = 16'h116; i <= 16'h11A; i++) good(i);
    do_reset();

    // Randomised ramp with corruption, jumps, gaps and clears.
    r = int'($urandom_range(0, 65535));
    for (int n = 0; n < 1200; n++) begin
      int pick;
      int av, bv, cv, dv;
      bit clr;
      pick = int'($urandom_range(0, 99));
      clr  = ($urandom_range(0, 99) < 3);
      if (pick < 10) begin
        gap();
      end else begin
        if (pick < 12) r = int'($urandom_range(0, 65535));
        av = r & 32'hFFFF;
        bv = (65536 - av) % 65536;
        cv = av / 2;
        dv = DC;
        if (pick >= 95) begin
          case ($urandom_range(0, 3))
            0: av = (av ^ int'($urandom_range(1, 65535))) & 32'hFFFF;
            1: bv = (bv ^ int'($urandom_range(1, 65535))) & 32'hFFFF;
            2: cv = (cv ^ int'($urandom_range(1, 65535))) & 32'hFFFF;
            default: dv = (dv ^ int'($urandom_range(1, 65535))) & 32'hFFFF;
          endcase
        end
        cycle(1, av, bv, cv, dv, clr);
        r = (r + 1) & 32'hFFFF;
      end
      if (n == 600) do_reset();
    end

    @(negedge clk);
    in_valid = 1'b0; clear_stats = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
